// File: rtl/ram_arb_pkg.sv
// Shared defaults and the rotating-priority search used by the RAM port
// arbiter and any other round-robin arbiter in the core.
package ram_arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;
   localparam int RR_MAX     = 32;

   typedef struct packed {
      logic       found;
      logic [7:0] idx;
   } rr_pick_t;

   // First set bit of req scanning start, start+1, ... modulo n.
   function automatic rr_pick_t rr_pick(
      input logic [RR_MAX-1:0] req,
      input int                n,
      input int                start
   );
      rr_pick_t r;
      int       k;
      r = '0;
      for (int i = RR_MAX - 1; i >= 0; i--) begin
         if (i < n) begin
            k = start + i;
            if (k >= n) k = k - n;
            if (req[k[4:0]]) begin
               r.found = 1'b1;
               r.idx   = k[7:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_ram_port_arbiter_rr_priority_pick.sv
// Combinational rotating priority encoder: picks the first request at or
// after start, wrapping around N requesters.
module rr_priority_pick
   import ram_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] idx,
   output logic [N-1:0]  onehot
);

   rr_pick_t          pick;
   logic [RR_MAX-1:0] req_ext;

   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
      pick           = rr_pick(req_ext, N, int'(start));
      found          = pick.found;
      idx            = pick.idx[IW-1:0];
      onehot         = '0;
      if (pick.found) onehot[idx] = 1'b1;
   end

endmodule

// File: rtl/sync_ram_port_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one registered-output
// RAM port; tags each read so its data returns to the issuing requester.
module sync_ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         ram_addr,
   output logic [DATA_W-1:0]         ram_data,
   output logic                      ram_we,
   input  logic [DATA_W-1:0]         ram_q
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);
   localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

   logic               own_vld;
   logic [IW-1:0]      owner;
   logic [BW-1:0]      burst_cnt;
   logic [NUM_REQ-1:0] rd_pend;

   logic [NUM_REQ-1:0] owner_oh;
   logic [NUM_REQ-1:0] scan_req;
   logic [IW-1:0]      start;
   logic               others;
   logic               own_req;
   logic               at_max;
   logic               stay;
   logic               excl;
   logic               pick_found;
   logic [IW-1:0]      pick_idx;
   logic [NUM_REQ-1:0] pick_oh;
   logic               any_gnt;
   logic [IW-1:0]      gnt_idx;

   always_comb begin
      owner_oh        = '0;
      owner_oh[owner] = 1'b1;
      others   = |(req & ~owner_oh);
      own_req  = own_vld & req[owner];
      at_max   = burst_cnt >= BMAX;
      stay     = own_req & (~at_max | ~others);
      // An owner that used up its burst drops out of the scan entirely.
      excl     = own_req & at_max & others;
      scan_req = excl ? (req & ~owner_oh) : req;
      start    = (owner == LAST) ? '0 : owner + 1'b1;
   end

   rr_priority_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req    (scan_req),
      .start  (start),
      .found  (pick_found),
      .idx    (pick_idx),
      .onehot (pick_oh)
   );

   always_comb begin
      any_gnt = 1'b0;
      gnt_idx = '0;
      gnt     = '0;
      if (rst) begin
         any_gnt = 1'b0;
      end else if (stay) begin
         any_gnt = 1'b1;
         gnt_idx = owner;
         gnt     = owner_oh;
      end else if (pick_found) begin
         any_gnt = 1'b1;
         gnt_idx = pick_idx;
         gnt     = pick_oh;
      end
   end

   always_comb begin
      ram_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      ram_data = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
      ram_we   = any_gnt & req_we[gnt_idx];
      rvalid   = rst ? '0 : rd_pend;
      rdata    = ram_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         own_vld   <= 1'b0;
         owner     <= LAST;
         burst_cnt <= '0;
         rd_pend   <= '0;
      end else begin
         rd_pend <= gnt & ~req_we;
         if (any_gnt) begin
            own_vld <= 1'b1;
            owner   <= gnt_idx;
            if (own_vld && gnt_idx == owner)
               burst_cnt <= at_max ? burst_cnt : burst_cnt + 1'b1;
            else
               burst_cnt <= BW'(1);
         end else begin
            own_vld   <= 1'b0;
            burst_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sync_ram_port_arbiter.sv
// Directed bench: two arbiter instances (burst 4 and burst 1), each on
// its own behavioural write-through RAM.
module tb_sync_ram_port_arbiter;

   logic        clk;
   logic        rst;
   int          tests;
   int          fails;

   logic [3:0]  a_req, a_we;
   logic [63:0] a_addr;
   logic [31:0] a_wdata;
   logic [3:0]  a_gnt, a_rvalid;
   logic [7:0]  a_rdata, a_ram_data, a_ram_q;
   logic [15:0] a_ram_addr;
   logic        a_ram_we;

   logic [3:0]  b_req, b_we;
   logic [63:0] b_addr;
   logic [31:0] b_wdata;
   logic [3:0]  b_gnt, b_rvalid;
   logic [7:0]  b_rdata, b_ram_data, b_ram_q;
   logic [15:0] b_ram_addr;
   logic        b_ram_we;

   logic [7:0]  mem_a [0:65535];
   logic [7:0]  mem_b [0:65535];

   sync_ram_port_arbiter #(.MAX_BURST(4)) u_a (
      .clk(clk), .rst(rst), .req(a_req), .req_we(a_we),
      .req_addr(a_addr), .req_wdata(a_wdata), .gnt(a_gnt),
      .rvalid(a_rvalid), .rdata(a_rdata), .ram_addr(a_ram_addr),
      .ram_data(a_ram_data), .ram_we(a_ram_we), .ram_q(a_ram_q)
   );

   sync_ram_port_arbiter #(.MAX_BURST(1)) u_b (
      .clk(clk), .rst(rst), .req(b_req), .req_we(b_we),
      .req_addr(b_addr), .req_wdata(b_wdata), .gnt(b_gnt),
      .rvalid(b_rvalid), .rdata(b_rdata), .ram_addr(b_ram_addr),
      .ram_data(b_ram_data), .ram_we(b_ram_we), .ram_q(b_ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (a_ram_we) mem_a[a_ram_addr] <= a_ram_data;
      a_ram_q <= a_ram_we ? a_ram_data : mem_a[a_ram_addr];
      if (b_ram_we) mem_b[b_ram_addr] <= b_ram_data;
      b_ram_q <= b_ram_we ? b_ram_data : mem_b[b_ram_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_a(input int i, input logic we,
                        input logic [15:0] addr, input logic [7:0] d);
      a_req[i]            = 1'b1;
      a_we[i]             = we;
      a_addr[i*16 +: 16]  = addr;
      a_wdata[i*8 +: 8]   = d;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      a_req = 4'b1111;
      a_we  = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         step();
         #1;
         tests++;
         if (a_gnt !== 4'b0000 || a_rvalid !== 4'b0000 || a_ram_we !== 1'b0) begin
            fails++;
            $display("FAIL reset gnt=%b rvalid=%b we=%b required 0000/0000/0",
                     a_gnt, a_rvalid, a_ram_we);
         end
      end
      step();
      rst = 1'b0;
      #1;
      tests++;
      if (a_gnt !== 4'b0001) begin
         fails++;
         $display("FAIL reset_release gnt=%b required 0001", a_gnt);
      end
      a_req = 4'b0000;
      a_we  = 4'b0000;
   endtask

   task automatic test_write_read();
      step();
      set_a(0, 1'b1, 16'h1234, 8'hA5);
      #1;
      tests++;
      if (a_gnt !== 4'b0001 || a_ram_we !== 1'b1 || a_ram_addr !== 16'h1234) begin
         fails++;
         $display("FAIL wr_grant gnt=%b we=%b addr=%h required 0001/1/1234",
                  a_gnt, a_ram_we, a_ram_addr);
      end
      step();
      set_a(0, 1'b0, 16'h1234, 8'h00);
      #1;
      tests++;
      if (a_gnt !== 4'b0001 || a_rvalid !== 4'b0000 || a_ram_we !== 1'b0) begin
         fails++;
         $display("FAIL rd_grant gnt=%b rvalid=%b we=%b required 0001/0000/0",
                  a_gnt, a_rvalid, a_ram_we);
      end
      step();
      a_req = 4'b0000;
      #1;
      tests++;
      if (a_rvalid !== 4'b0001 || a_rdata !== 8'hA5) begin
         fails++;
         $display("FAIL rd_return rvalid=%b rdata=%h required 0001/a5",
                  a_rvalid, a_rdata);
      end
      step();
      #1;
      tests++;
      if (a_rvalid !== 4'b0000) begin
         fails++;
         $display("FAIL rd_once rvalid=%b required 0000", a_rvalid);
      end
   endtask

   task automatic test_burst_limit();
      logic [3:0] exp_g [9];
      exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_a(0, 1'b0, 16'h0010, 8'h00);
      set_a(2, 1'b0, 16'h0020, 8'h00);
      for (int c = 0; c < 9; c++) begin
         #1;
         tests++;
         if (a_gnt !== exp_g[c]) begin
            fails++;
            $display("FAIL burst_cycle%0d gnt=%b required %b", c, a_gnt, exp_g[c]);
         end
         step();
      end
      a_req = 4'b0001;
      for (int c = 0; c < 8; c++) begin
         #1;
         tests++;
         if (a_gnt !== 4'b0001) begin
            fails++;
            $display("FAIL lone_cycle%0d gnt=%b required 0001", c, a_gnt);
         end
         step();
      end
      a_req = 4'b0000;
   endtask

   task automatic test_rotation();
      logic [3:0] exp_g [7];
      exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
      step();
      rst = 1'b1;
      step();
      rst   = 1'b0;
      b_req = 4'b1011;
      for (int c = 0; c < 7; c++) begin
         #1;
         tests++;
         if (b_gnt !== exp_g[c]) begin
            fails++;
            $display("FAIL rot_cycle%0d gnt=%b required %b", c, b_gnt, exp_g[c]);
         end
         step();
      end
      b_req = 4'b0000;
      #1;
      tests++;
      if (b_gnt !== 4'b0000) begin
         fails++;
         $display("FAIL rot_idle gnt=%b required 0000", b_gnt);
      end
      step();
      b_req = 4'b1111;
      #1;
      tests++;
      if (b_gnt !== 4'b0010) begin
         fails++;
         $display("FAIL rot_after_idle gnt=%b required 0010", b_gnt);
      end
      step();
      b_req = 4'b0000;
   endtask

   task automatic test_read_tagging();
      step();
      a_req = 4'b0000;
      set_a(1, 1'b1, 16'h0005, 8'h11);
      step();
      a_req = 4'b0000;
      set_a(3, 1'b1, 16'h0006, 8'h33);
      step();
      a_req = 4'b0000;
      set_a(1, 1'b0, 16'h0005, 8'h00);
      #1;
      tests++;
      if (a_gnt !== 4'b0010 || a_rvalid !== 4'b0000) begin
         fails++;
         $display("FAIL tag_rd1 gnt=%b rvalid=%b required 0010/0000",
                  a_gnt, a_rvalid);
      end
      step();
      a_req = 4'b0000;
      set_a(3, 1'b0, 16'h0006, 8'h00);
      #1;
      tests++;
      if (a_gnt !== 4'b1000 || a_rvalid !== 4'b0010 || a_rdata !== 8'h11) begin
         fails++;
         $display("FAIL tag_ret1 gnt=%b rvalid=%b rdata=%h required 1000/0010/11",
                  a_gnt, a_rvalid, a_rdata);
      end
      step();
      a_req = 4'b0000;
      #1;
      tests++;
      if (a_rvalid !== 4'b1000 || a_rdata !== 8'h33) begin
         fails++;
         $display("FAIL tag_ret3 rvalid=%b rdata=%h required 1000/33",
                  a_rvalid, a_rdata);
      end
   endtask

   task automatic test_reset_mid_read();
      step();
      a_req = 4'b0000;
      set_a(2, 1'b0, 16'h0005, 8'h00);
      #1;
      tests++;
      if (a_gnt !== 4'b0100) begin
         fails++;
         $display("FAIL mid_grant gnt=%b required 0100", a_gnt);
      end
      step();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         tests++;
         if (a_gnt !== 4'b0000 || a_rvalid !== 4'b0000) begin
            fails++;
            $display("FAIL mid_rst%0d gnt=%b rvalid=%b required 0000/0000",
                     c, a_gnt, a_rvalid);
         end
         step();
      end
      rst   = 1'b0;
      a_req = 4'b0000;
      for (int c = 0; c < 2; c++) begin
         #1;
         tests++;
         if (a_rvalid !== 4'b0000) begin
            fails++;
            $display("FAIL mid_after%0d rvalid=%b required 0000", c, a_rvalid);
         end
         step();
      end
      a_req = 4'b1111;
      a_we  = 4'b0000;
      #1;
      tests++;
      if (a_gnt !== 4'b0001) begin
         fails++;
         $display("FAIL mid_restart gnt=%b required 0001", a_gnt);
      end
      step();
      a_req = 4'b0000;
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      rst     = 1'b1;
      a_req   = '0;
      a_we    = '0;
      a_addr  = '0;
      a_wdata = '0;
      b_req   = '0;
      b_we    = '0;
      b_addr  = '0;
      b_wdata = '0;
      test_reset();
      test_write_read();
      test_burst_limit();
      test_rotation();
      test_read_tagging();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
